// File: rtl/hsv_conv_if.sv
// Request/response bundle for hsv_conv_arbiter: NUM_REQ HSV request ports and one tagged RGB565 response channel.
// Handshake: a transfer happens on a clock edge where valid and ready are both high; valid is never withdrawn by the sink's ready.
interface hsv_conv_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [24*NUM_REQ-1:0] req_hsv;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [15:0]           rsp_rgb;

  modport master (
    output req_valid, req_hsv, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_rgb
  );

  modport slave (
    input  req_valid, req_hsv, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_rgb
  );
endinterface

// File: rtl/hsv_conv_arbiter.sv
// Round-robin arbiter sharing one registered HSV->RGB565 converter among NUM_REQ requesters.
// Optional one-entry result cache enabled by defining HSV_CONV_CACHE_EN.
module hsv_conv_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  hsv_conv_if.slave  bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, gnt_id, hold_id_q, rsp_id_q;
  logic                gnt_found, arb_en, accept, cache_hit;
  logic [NUM_REQ-1:0]  ready;
  logic [23:0]         gnt_hsv, hold_hsv_q;
  logic [15:0]         conv_rgb, rsp_rgb_q, cache_rgb;
  int                  idx;

  function automatic logic [15:0] hsv_to_rgb(input logic [23:0] hsv);
    logic [7:0] h, s, v, region, rem, p, q, t, sr, st, r, g, b;
    h = hsv[23:16];
    s = hsv[15:8];
    v = hsv[7:0];
    region = h / 8'd43;
    rem    = 8'((h - region * 8'd43) * 8'd6);
    p  = 8'(({8'd0, v} * {8'd0, ~s}) >> 8);
    sr = 8'(({8'd0, s} * {8'd0, rem}) >> 8);
    q  = 8'(({8'd0, v} * {8'd0, ~sr}) >> 8);
    st = 8'(({8'd0, s} * {8'd0, ~rem}) >> 8);
    t  = 8'(({8'd0, v} * {8'd0, ~st}) >> 8);
    if (s == 8'd0) begin
      r = v; g = v; b = v;
    end else begin
      case (region)
        8'd0:    begin r = v; g = t; b = p; end
        8'd1:    begin r = q; g = v; b = p; end
        8'd2:    begin r = p; g = v; b = t; end
        8'd3:    begin r = p; g = q; b = v; end
        8'd4:    begin r = t; g = p; b = v; end
        default: begin r = v; g = p; b = q; end
      endcase
    end
    return {5'(({8'd0, r} * 16'd31) / 16'd255),
            6'(({8'd0, g} * 16'd63) / 16'd255),
            5'(({8'd0, b} * 16'd31) / 16'd255)};
  endfunction

  // First pending requester at or after the pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_found && bus.req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
  end

  assign gnt_hsv = bus.req_hsv[int'(gnt_id)*24 +: 24];
  assign arb_en  = rst_n && ((state_q == IDLE) || ((state_q == HOLD) && bus.rsp_ready));
  assign accept  = arb_en && gnt_found;

  always_comb begin
    ready = '0;
    if (accept) ready[gnt_id] = 1'b1;
  end

  assign conv_rgb = hsv_to_rgb(hold_hsv_q);

`ifdef HSV_CONV_CACHE_EN
  logic        cache_valid_q;
  logic [23:0] cache_hsv_q;
  logic [15:0] cache_rgb_q;

  // Refreshed by every real conversion; the requester id plays no part in a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid_q <= 1'b0;
      cache_hsv_q   <= '0;
      cache_rgb_q   <= '0;
    end else if (state_q == CONVERT) begin
      cache_valid_q <= 1'b1;
      cache_hsv_q   <= hold_hsv_q;
      cache_rgb_q   <= conv_rgb;
    end
  end

  assign cache_hit = cache_valid_q && (cache_hsv_q == gnt_hsv);
  assign cache_rgb = cache_rgb_q;
`else
  assign cache_hit = 1'b0;
  assign cache_rgb = 16'h0000;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = cache_hit ? HOLD : CONVERT;
      end
      CONVERT: state_d = HOLD;
      HOLD: begin
        if (bus.rsp_ready) begin
          if (accept) state_d = cache_hit ? HOLD : CONVERT;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_hsv_q <= '0;
      hold_id_q  <= '0;
      rsp_id_q   <= '0;
      rsp_rgb_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ptr_q      <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        hold_hsv_q <= gnt_hsv;
        hold_id_q  <= gnt_id;
        if (cache_hit) begin
          rsp_rgb_q <= cache_rgb;
          rsp_id_q  <= gnt_id;
        end
      end
      if (state_q == CONVERT) begin
        rsp_rgb_q <= conv_rgb;
        rsp_id_q  <= hold_id_q;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state_q == HOLD);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_rgb   = rsp_rgb_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_hsv_conv_arbiter.sv
// Directed bench for hsv_conv_arbiter: reset, single request, round robin, backpressure,
// hue boundaries, reset abort and repeated-colour latency (HSV_CONV_CACHE_EN aware).
module tb_hsv_conv_arbiter;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

`ifdef HSV_CONV_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 2;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_fail;
  logic [17:0] exp_q[$];

  hsv_conv_if #(.NUM_REQ(4), .ID_W(2)) bus ();

  hsv_conv_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_hsv   = '0;
    bus.rsp_ready = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_checks++;
    if (bus.rsp_rgb !== 16'h0000) begin n_fail++; $display("FAIL reset_rsp_rgb: got %h want 0000", bus.rsp_rgb); end
    n_checks++;
    if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
    n_checks++;
    if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d want 0", bus.rsp_id); end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b want 0001", bus.req_ready); end
    bus.req_valid = 4'b0000;
    tick();
    n_checks++;
    if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_withdrawn_idle: state %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_single();
    bus.req_hsv[23:0] = {8'd0, 8'd255, 8'd255};
    bus.rsp_ready     = 1'b1;
    bus.req_valid     = 4'b0001;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || dbg_state !== ST_CONVERT) begin
      n_fail++; $display("FAIL single_edge1: rsp_valid=%b state=%0d want 0/%0d", bus.rsp_valid, dbg_state, ST_CONVERT);
    end
    tick();
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rgb !== 16'hF800 || bus.rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL single_rsp: valid=%b rgb=%h id=%0d want 1/F800/0", bus.rsp_valid, bus.rsp_rgb, bus.rsp_id);
    end
    tick();
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop: rsp_valid=%b want 0", bus.rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [15:0] rgb_tab [4];
    logic [17:0] exp;
    rgb_tab[0] = 16'h07E0; rgb_tab[1] = 16'h001F; rgb_tab[2] = 16'h7BEF; rgb_tab[3] = 16'hF800;
    bus.req_hsv[23:0]  = {8'd86,  8'd255, 8'd255};
    bus.req_hsv[47:24] = {8'd172, 8'd255, 8'd255};
    bus.req_hsv[71:48] = {8'd0,   8'd0,   8'd128};
    bus.req_hsv[95:72] = {8'd0,   8'd255, 8'd255};
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    pulse_reset();
    #1;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back({2'(k % 4), rgb_tab[k % 4]});
      n_checks++;
      if (bus.req_ready !== 4'(1 << (k % 4))) begin
        n_fail++; $display("FAIL rr_grant_%0d: req_ready=%b want %b", k, bus.req_ready, 4'(1 << (k % 4)));
      end
      tick();
      n_checks++;
      if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL rr_convert_%0d: req_ready=%b rsp_valid=%b want 0000/0", k, bus.req_ready, bus.rsp_valid);
      end
      tick();
      exp = exp_q.pop_front();
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== exp[17:16] || bus.rsp_rgb !== exp[15:0]) begin
        n_fail++; $display("FAIL rr_rsp_%0d: valid=%b id=%0d rgb=%h want 1/%0d/%h",
                           k, bus.rsp_valid, bus.rsp_id, bus.rsp_rgb, exp[17:16], exp[15:0]);
      end
    end
    bus.req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0011;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant: req_ready=%b want 0010", bus.req_ready); end
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_rgb !== 16'h001F || bus.req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL bp_hold_%0d: valid=%b id=%0d rgb=%h ready=%b want 1/1/001F/0000",
                           c, bus.rsp_valid, bus.rsp_id, bus.rsp_rgb, bus.req_ready);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_release_grant: req_ready=%b want 0001", bus.req_ready); end
    tick();
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || dbg_state !== ST_CONVERT) begin
      n_fail++; $display("FAIL bp_release_convert: valid=%b state=%0d want 0/%0d", bus.rsp_valid, dbg_state, ST_CONVERT);
    end
    tick();
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_rgb !== 16'h07E0) begin
      n_fail++; $display("FAIL bp_next_rsp: valid=%b id=%0d rgb=%h want 1/0/07E0", bus.rsp_valid, bus.rsp_id, bus.rsp_rgb);
    end
    bus.req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_hue_boundary();
    logic [23:0] hsv_tab [2];
    logic [15:0] rgb_tab [2];
    hsv_tab[0] = {8'd43,  8'd255, 8'd255}; rgb_tab[0] = 16'hF7E0;
    hsv_tab[1] = {8'd255, 8'd255, 8'd255}; rgb_tab[1] = 16'hF801;
    for (int n = 0; n < 2; n++) begin
      bus.req_hsv[47:24] = hsv_tab[n];
      bus.req_valid      = 4'b0010;
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL hue_grant_%0d: req_ready=%b want 0010", n, bus.req_ready); end
      tick();
      bus.req_valid = 4'b0000;
      tick();
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_rgb !== rgb_tab[n]) begin
        n_fail++; $display("FAIL hue_rsp_%0d: valid=%b id=%0d rgb=%h want 1/1/%h", n, bus.rsp_valid, bus.rsp_id, bus.rsp_rgb, rgb_tab[n]);
      end
      tick();
    end
  endtask

  task automatic test_reset_abort();
    bus.req_valid = 4'b0100;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL abort_grant: req_ready=%b want 0100", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dbg_state !== ST_IDLE || bus.rsp_valid !== 1'b0 || bus.rsp_rgb !== 16'h0000) begin
      n_fail++; $display("FAIL abort_async: state=%0d valid=%b rgb=%h want %0d/0/0000", dbg_state, bus.rsp_valid, bus.rsp_rgb, ST_IDLE);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL abort_no_rsp_%0d: rsp_valid=%b want 0", c, bus.rsp_valid); end
    end
    bus.req_valid = 4'b1111;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL abort_ptr: req_ready=%b want 0001", bus.req_ready); end
    bus.req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_back_to_back_same_colour();
    int lat;
    bus.req_hsv[95:72] = {8'd0, 8'd255, 8'd255};
    bus.req_hsv[47:24] = {8'd0, 8'd255, 8'd255};
    bus.rsp_ready      = 1'b1;
    // first request: cache is empty after the abort reset
    bus.req_valid = 4'b1000;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL same1_grant: req_ready=%b want 1000", bus.req_ready); end
    tick();
    lat = 1;
    bus.req_valid = 4'b0000;
    while (!bus.rsp_valid && lat < 5) begin tick(); lat++; end
    n_checks++;
    if (lat !== 2 || bus.rsp_rgb !== 16'hF800 || bus.rsp_id !== 2'd3) begin
      n_fail++; $display("FAIL same1_rsp: latency=%0d rgb=%h id=%0d want 2/F800/3", lat, bus.rsp_rgb, bus.rsp_id);
    end
    tick();
    bus.req_valid = 4'b0010;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL same2_grant: req_ready=%b want 0010", bus.req_ready); end
    tick();
    lat = 1;
    bus.req_valid = 4'b0000;
    while (!bus.rsp_valid && lat < 5) begin tick(); lat++; end
    n_checks++;
    if (lat !== HIT_LAT || bus.rsp_rgb !== 16'hF800 || bus.rsp_id !== 2'd1) begin
      n_fail++; $display("FAIL same2_rsp: latency=%0d rgb=%h id=%0d want %0d/F800/1", lat, bus.rsp_rgb, bus.rsp_id, HIT_LAT);
    end
    tick();
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL same2_drop: rsp_valid=%b want 0", bus.rsp_valid); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_hue_boundary();
    test_reset_abort();
    test_back_to_back_same_colour();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
